// File: rtl/icache_loader_arbiter.sv
// -----------------------------------------------------------------------------
// icache_loader_arbiter
//
// Owns the single port of the instruction cache and shares it between the CPU
// fetch path and a byte-serial program loader. Loader bytes are packed into
// 16-bit words (high byte first) and written to consecutive cache indices
// starting at 0. CPU fetches are stalled for the whole duration of a load.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   load_start, load_count   begin a load of load_count words (IDLE only)
//   load_abort               cancel a load in progress
//   byte_valid/byte_data     loader byte stream, accepted with byte_ready
//   load_done, load_error    1-cycle completion / error pulses
//   busy                     high whenever a load sequence is active
//   cpu_req, cpu_index       CPU fetch request and word index
//   cpu_grant                fetch accepted this cycle (combinational)
//   cpu_data, cpu_data_valid fetched word, valid the cycle after a grant
//   cache_not_enable         icache read disable (high = no read)
//   cache_index, cache_data  icache read index / registered read data
//   cache_download           icache write enable (icache writes on negedge)
//   cache_wr_index/data      icache write index / data
// -----------------------------------------------------------------------------
module icache_loader_arbiter #(
   parameter int DEPTH = 1000,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_start,
   input  logic [CNT_W-1:0] load_count,
   input  logic             load_abort,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             load_done,
   output logic             load_error,
   output logic             busy,
   input  logic             cpu_req,
   input  logic [31:0]      cpu_index,
   output logic             cpu_grant,
   output logic [15:0]      cpu_data,
   output logic             cpu_data_valid,
   output logic             cache_not_enable,
   output logic [31:0]      cache_index,
   input  logic [15:0]      cache_data,
   output logic             cache_download,
   output logic [31:0]      cache_wr_index,
   output logic [15:0]      cache_wr_data
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOAD_HI = 3'd1;
   localparam logic [2:0] LOAD_LO = 3'd2;
   localparam logic [2:0] WRITE   = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   localparam logic [CNT_W-1:0] DEPTH_W = CNT_W'(DEPTH);

   logic [2:0]       state;
   logic [CNT_W-1:0] wcnt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] wcnt_inc;
   logic [7:0]       hi;
   logic             download_q;

   assign wcnt_inc = wcnt + CNT_W'(1);

   // The CPU only gets the port in IDLE, and a simultaneous load_start wins.
   // Gating with rst keeps the read port disabled while reset is held.
   assign busy             = (state != IDLE);
   assign cpu_grant        = !rst && (state == IDLE) && cpu_req && !load_start;
   assign cache_not_enable = !cpu_grant;
   assign cache_index      = cpu_index;
   assign cpu_data         = cache_data;
   assign byte_ready       = (state == LOAD_HI) || (state == LOAD_LO);

   // The write strobe is registered (high exactly in WRITE); an abort arriving
   // during WRITE must still cancel that write, hence the final gate.
   assign cache_download   = download_q && !load_abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wcnt           <= '0;
         count          <= '0;
         hi             <= '0;
         download_q     <= 1'b0;
         load_done      <= 1'b0;
         load_error     <= 1'b0;
         cpu_data_valid <= 1'b0;
         cache_wr_index <= '0;
         cache_wr_data  <= '0;
      end else begin
         load_done      <= 1'b0;
         load_error     <= 1'b0;
         download_q     <= 1'b0;
         cpu_data_valid <= cpu_grant;
         case (state)
            IDLE: begin
               if (load_start) begin
                  if (load_count == '0) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                  end else if (load_count > DEPTH_W) begin
                     load_error <= 1'b1;
                  end else begin
                     state <= LOAD_HI;
                     wcnt  <= '0;
                     count <= load_count;
                  end
               end
            end
            LOAD_HI: begin
               if (load_abort) begin
                  state      <= IDLE;
                  load_error <= 1'b1;
               end else if (byte_valid) begin
                  hi    <= byte_data;
                  state <= LOAD_LO;
               end
            end
            LOAD_LO: begin
               // The low byte goes straight into the write data register, so
               // no separate low-byte holding register is needed.
               if (load_abort) begin
                  state      <= IDLE;
                  load_error <= 1'b1;
               end else if (byte_valid) begin
                  cache_wr_data  <= {hi, byte_data};
                  cache_wr_index <= 32'(wcnt);
                  download_q     <= 1'b1;
                  state          <= WRITE;
               end
            end
            WRITE: begin
               if (load_abort) begin
                  state      <= IDLE;
                  load_error <= 1'b1;
               end else begin
                  wcnt <= wcnt_inc;
                  if (wcnt_inc == count) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                  end else begin
                     state <= LOAD_HI;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_loader_arbiter.sv
// -----------------------------------------------------------------------------
// tb_icache_loader_arbiter
//
// Drives randomized program loads, aborts, resets and CPU fetches into the
// arbiter, with a behavioural icache attached. Expected cache contents come
// from a plain word array updated from the byte stream of each load.
// -----------------------------------------------------------------------------
module tb_icache_loader_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_start;
   logic [15:0] load_count;
   logic        load_abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        load_done;
   logic        load_error;
   logic        busy;
   logic        cpu_req;
   logic [31:0] cpu_index;
   logic        cpu_grant;
   logic [15:0] cpu_data;
   logic        cpu_data_valid;
   logic        cache_not_enable;
   logic [31:0] cache_index;
   logic [15:0] cache_data = 16'h0;
   logic        cache_download;
   logic [31:0] cache_wr_index;
   logic [15:0] cache_wr_data;

   always #5 clk = ~clk;

   icache_loader_arbiter #(.DEPTH(1000), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .load_count(load_count), .load_abort(load_abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .load_done(load_done), .load_error(load_error), .busy(busy),
      .cpu_req(cpu_req), .cpu_index(cpu_index), .cpu_grant(cpu_grant),
      .cpu_data(cpu_data), .cpu_data_valid(cpu_data_valid),
      .cache_not_enable(cache_not_enable), .cache_index(cache_index),
      .cache_data(cache_data), .cache_download(cache_download),
      .cache_wr_index(cache_wr_index), .cache_wr_data(cache_wr_data)
   );

   logic [15:0] mem     [0:1023];
   logic [15:0] ref_mem [0:1023];
   logic [7:0]  load_bytes [0:2047];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_idx = '0;
   logic [15:0] pre_data = '0;
   bit          cpu_noise = 1'b0;
   int dl_cnt = 0, done_cnt = 0, err_cnt = 0, gwb_cnt = 0;
   int chk_cnt = 0, pass_cnt = 0;

   // Behavioural icache: registered read (0 when disabled), negedge write.
   always @(posedge clk)
      cache_data <= (cache_not_enable || cache_index >= 32'd1024) ? 16'h0 : mem[cache_index[9:0]];

   // Icache write port plus pulse monitors sampled away from the active edge.
   always @(negedge clk) begin
      if (pre_we) mem[pre_idx] <= pre_data;
      if (cache_download && cache_wr_index < 32'd1024) mem[cache_wr_index[9:0]] <= cache_wr_data;
      if (cache_download) dl_cnt <= dl_cnt + 1;
      if (load_done) done_cnt <= done_cnt + 1;
      if (load_error) err_cnt <= err_cnt + 1;
      if (cpu_grant && busy) gwb_cnt <= gwb_cnt + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input int idx, input logic [15:0] d);
      pre_we = 1'b1; pre_idx = 10'(idx); pre_data = d;
      ref_mem[idx] = d;
      @(negedge clk);
      #1 pre_we = 1'b0;
      step();
   endtask

   // Offer one loader byte after a random idle gap and wait for acceptance.
   task automatic applyStimulus(input logic [7:0] d, input int max_gap);
      bit acc;
      acc = 1'b0;
      byte_valid = 1'b0;
      repeat ($urandom_range(0, max_gap)) step();
      byte_valid = 1'b1;
      byte_data  = d;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (cpu_noise) begin
            cpu_req   = 1'($urandom);
            cpu_index = 32'($urandom_range(0, 15));
         end
         @(negedge clk);
         acc = byte_ready;
         step();
      end
      byte_valid = 1'b0;
      if (!acc) checkOutput("byte_timeout", 32'(0), 32'(1));
   endtask

   task automatic waitDone(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (load_done) seen = 1'b1;
         step();
      end
   endtask

   task automatic doFetch(input int idx, input string tag);
      cpu_req = 1'b1; cpu_index = 32'(idx);
      @(negedge clk);
      checkOutput({tag, "_grant"}, 32'(cpu_grant), 32'(1));
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput({tag, "_valid"}, 32'(cpu_data_valid), 32'(1));
      checkOutput({tag, "_data"}, 32'(cpu_data), 32'(ref_mem[idx]));
      step();
   endtask

   // One load of `count` words from load_bytes; abort_after >= 0 aborts once
   // that many bytes have been accepted.
   task automatic runLoad(input int count, input int abort_after, input int max_gap, input string tag);
      int dl0, done0, err0, words;
      bit seen;
      dl0 = dl_cnt; done0 = done_cnt; err0 = err_cnt;
      load_count = 16'(count); load_start = 1'b1;
      step();
      load_start = 1'b0;
      if (abort_after < 0) begin
         for (int i = 0; i < 2 * count; i++) applyStimulus(load_bytes[i], max_gap);
         waitDone(seen);
         checkOutput({tag, "_done_seen"}, 32'(seen), 32'(1));
         words = count;
      end else begin
         for (int i = 0; i < abort_after; i++) applyStimulus(load_bytes[i], max_gap);
         load_abort = 1'b1; byte_valid = 1'b1; byte_data = 8'($urandom);
         step();
         load_abort = 1'b0; byte_valid = 1'b0;
         @(negedge clk);
         checkOutput({tag, "_err_pulse"}, 32'(load_error), 32'(1));
         checkOutput({tag, "_idle"}, 32'(busy), 32'(0));
         step();
         // Odd count: abort lands in LOAD_LO. Even non-zero: it lands in the
         // WRITE of the last complete word, which is then cancelled.
         if (abort_after % 2 == 1) words = (abort_after - 1) / 2;
         else if (abort_after == 0) words = 0;
         else words = abort_after / 2 - 1;
      end
      cpu_req = 1'b0;
      step(); step();
      checkOutput({tag, "_writes"}, 32'(dl_cnt - dl0), 32'(words));
      checkOutput({tag, "_dones"}, 32'(done_cnt - done0), 32'((abort_after < 0) ? 1 : 0));
      checkOutput({tag, "_errs"}, 32'(err_cnt - err0), 32'((abort_after < 0) ? 0 : 1));
      for (int w = 0; w < words; w++) ref_mem[w] = {load_bytes[2 * w], load_bytes[2 * w + 1]};
   endtask

   initial begin
      int dl0, done0, err0, cnt, ab;
      bit seen;
      rst = 1'b1; load_start = 1'b0; load_count = '0; load_abort = 1'b0;
      byte_valid = 1'b0; byte_data = '0; cpu_req = 1'b0; cpu_index = '0;

      // T1 reset values
      #12;
      checkOutput("rst_busy", 32'(busy), 32'(0));
      checkOutput("rst_not_enable", 32'(cache_not_enable), 32'(1));
      checkOutput("rst_download", 32'(cache_download), 32'(0));
      checkOutput("rst_data_valid", 32'(cpu_data_valid), 32'(0));
      checkOutput("rst_done", 32'(load_done), 32'(0));
      checkOutput("rst_error", 32'(load_error), 32'(0));
      checkOutput("rst_byte_ready", 32'(byte_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      step();

      for (int i = 0; i < 16; i++) preload(i, 16'($urandom));
      preload(10, 16'h0123);

      // T2 fetch
      doFetch(10, "t2_fetch");

      // T3 basic load
      load_bytes[0] = 8'h12; load_bytes[1] = 8'h34; load_bytes[2] = 8'h56; load_bytes[3] = 8'h78;
      runLoad(2, -1, 1, "t3");
      checkOutput("t3_model_cell1", 32'(ref_mem[1]), 32'h5678);
      doFetch(0, "t3_fetch0");
      doFetch(1, "t3_fetch1");

      // T4 collision: load wins, CPU stalls, grant resumes after load_done
      load_bytes[0] = 8'($urandom); load_bytes[1] = 8'($urandom);
      dl0 = dl_cnt;
      load_count = 16'd1; load_start = 1'b1; cpu_req = 1'b1; cpu_index = 32'd3;
      @(negedge clk);
      checkOutput("t4_collide_grant", 32'(cpu_grant), 32'(0));
      checkOutput("t4_collide_ne", 32'(cache_not_enable), 32'(1));
      step();
      load_start = 1'b0;
      applyStimulus(load_bytes[0], 2);
      applyStimulus(load_bytes[1], 2);
      waitDone(seen);
      checkOutput("t4_done_seen", 32'(seen), 32'(1));
      @(negedge clk);
      checkOutput("t4_resume_grant", 32'(cpu_grant), 32'(1));
      step();
      cpu_req = 1'b0;
      @(negedge clk);
      checkOutput("t4_resume_data", 32'(cpu_data), 32'(ref_mem[3]));
      step();
      checkOutput("t4_writes", 32'(dl_cnt - dl0), 32'(1));
      ref_mem[0] = {load_bytes[0], load_bytes[1]};
      doFetch(0, "t4_fetch0");

      // T5 errors: oversize load and empty load
      dl0 = dl_cnt; err0 = err_cnt; done0 = done_cnt;
      load_count = 16'd1001; load_start = 1'b1;
      step();
      load_start = 1'b0;
      @(negedge clk);
      checkOutput("t5_big_err", 32'(load_error), 32'(1));
      checkOutput("t5_big_busy", 32'(busy), 32'(0));
      step();
      load_count = 16'd0; load_start = 1'b1;
      step();
      load_start = 1'b0;
      @(negedge clk);
      checkOutput("t5_zero_done", 32'(load_done), 32'(1));
      step(); step();
      checkOutput("t5_writes", 32'(dl_cnt - dl0), 32'(0));
      checkOutput("t5_errs", 32'(err_cnt - err0), 32'(1));
      checkOutput("t5_dones", 32'(done_cnt - done0), 32'(1));

      // T6 abort after 3 bytes of a 4-word load
      preload(1, 16'hBEEF);
      load_bytes[0] = 8'hA1; load_bytes[1] = 8'hB2; load_bytes[2] = 8'hC3;
      runLoad(4, 3, 1, "t6_abort");
      checkOutput("t6_model_cell0", 32'(ref_mem[0]), 32'hA1B2);
      doFetch(0, "t6_fetch0");
      doFetch(1, "t6_fetch1");

      // T6 reset mid-LOAD_LO, then mid-WRITE (write strobe must drop at once)
      dl0 = dl_cnt;
      load_count = 16'd3; load_start = 1'b1;
      step();
      load_start = 1'b0;
      applyStimulus(8'h5A, 0);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6_rst_busy", 32'(busy), 32'(0));
      checkOutput("t6_rst_ready", 32'(byte_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      step();
      load_count = 16'd2; load_start = 1'b1;
      step();
      load_start = 1'b0;
      applyStimulus(8'h11, 0);
      applyStimulus(8'h22, 0);
      checkOutput("t6_write_strobe", 32'(cache_download), 32'(1));
      #1 rst = 1'b1;
      #1;
      checkOutput("t6_rst_strobe", 32'(cache_download), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      step();
      checkOutput("t6_rst_writes", 32'(dl_cnt - dl0), 32'(0));
      for (int i = 0; i < 4; i++) load_bytes[i] = 8'($urandom);
      runLoad(2, -1, 0, "t6_restart");
      doFetch(0, "t6_restart0");
      doFetch(1, "t6_restart1");

      // Randomized loads with CPU request noise and occasional aborts
      cpu_noise = 1'b1;
      for (int r = 0; r < 10; r++) begin
         cnt = int'($urandom_range(1, 6));
         ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2 * cnt - 1)) : -1;
         for (int i = 0; i < 2 * cnt; i++) load_bytes[i] = 8'($urandom);
         runLoad(cnt, ab, 2, $sformatf("rnd%0d", r));
         for (int i = 0; i <= cnt; i++) doFetch(i, $sformatf("rnd%0d_f%0d", r, i));
      end
      cpu_noise = 1'b0;

      // Maximum legal load length
      for (int i = 0; i < 2000; i++) load_bytes[i] = 8'($urandom);
      runLoad(1000, -1, 0, "full");
      doFetch(0, "full_f0");
      doFetch(500, "full_f500");
      doFetch(999, "full_f999");

      checkOutput("grant_while_busy", 32'(gwb_cnt), 32'(0));
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
